// File: rtl/dmem_bridge_if.sv
// Bus bundle between the CPU data port, dmem_bridge and the data memory.
// The bridge uses the master modport; the CPU/memory environment uses slave.
interface dmem_bridge_if;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_mem_w;
  logic        cpu_mem_r;
  logic [2:0]  cpu_dm_type;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    input  cpu_addr, cpu_wdata, cpu_mem_w, cpu_mem_r, cpu_dm_type, mem_rdata, mem_ack,
    output cpu_rdata, cpu_ready, cpu_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    output cpu_addr, cpu_wdata, cpu_mem_w, cpu_mem_r, cpu_dm_type, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ready, cpu_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/dmem_bridge.sv
// CPU load/store to word-wide memory bridge with lane steering and extension.
// Optional ack timeout enabled by defining DMEM_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for cpu_mem_w / cpu_mem_r; access latched on request
// REQ   | mem_req asserted from latched values until mem_ack (or timeout)
// DONE  | one-cycle completion; cpu_ready=1, cpu_err flags misalign/abort
module dmem_bridge #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic          clk,
  input logic          reset,
  dmem_bridge_if.master bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        mem_we_q, mem_we_d;
  logic [2:0]  type_q, type_d;
  logic [1:0]  lane_q, lane_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        req_in, is_half, is_byte, misalign_in;
  logic [3:0]  be_in;
  logic [31:0] wdata_in, load_ext;
  logic [15:0] rd_half;
  logic [7:0]  rd_byte;

`ifdef DMEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] count_q, count_d;
`endif

  always_comb begin
    req_in  = bus.cpu_mem_w | bus.cpu_mem_r;
    is_half = (bus.cpu_dm_type == 3'b001) || (bus.cpu_dm_type == 3'b010);
    is_byte = (bus.cpu_dm_type == 3'b011) || (bus.cpu_dm_type == 3'b100);
    // unlisted type codes are handled as word accesses
    misalign_in = is_half ? bus.cpu_addr[0] : (!is_byte && (bus.cpu_addr[1:0] != 2'b00));

    be_in    = 4'b1111;
    wdata_in = bus.cpu_wdata;
    if (is_byte) begin
      be_in    = 4'b0001 << bus.cpu_addr[1:0];
      wdata_in = {4{bus.cpu_wdata[7:0]}};
    end else if (is_half) begin
      be_in    = bus.cpu_addr[1] ? 4'b1100 : 4'b0011;
      wdata_in = {2{bus.cpu_wdata[15:0]}};
    end

    rd_half = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    rd_byte = bus.mem_rdata[8*lane_q +: 8];
    case (type_q)
      3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
      3'b010:  load_ext = {16'h0000, rd_half};
      3'b011:  load_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_ext = {24'h000000, rd_byte};
      default: load_ext = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    mem_we_d    = mem_we_q;
    type_d      = type_q;
    lane_d      = lane_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
`ifdef DMEM_TIMEOUT_EN
    count_d     = count_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_in) begin
          mem_addr_d  = {bus.cpu_addr[31:2], 2'b00};
          mem_wdata_d = wdata_in;
          mem_be_d    = be_in;
          mem_we_d    = bus.cpu_mem_w;
          type_d      = bus.cpu_dm_type;
          lane_d      = bus.cpu_addr[1:0];
          err_d       = misalign_in;
          state_d     = misalign_in ? ST_DONE : ST_REQ;
`ifdef DMEM_TIMEOUT_EN
          count_d     = '0;
`endif
        end
      end
      ST_REQ: begin
        if (bus.mem_ack) begin
          state_d = ST_DONE;
          err_d   = 1'b0;
          if (!mem_we_q) rdata_d = load_ext;
`ifdef DMEM_TIMEOUT_EN
        end else if (count_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
`endif
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      mem_we_q    <= 1'b0;
      type_q      <= '0;
      lane_q      <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
`ifdef DMEM_TIMEOUT_EN
      count_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      mem_we_q    <= mem_we_d;
      type_q      <= type_d;
      lane_q      <= lane_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
`ifdef DMEM_TIMEOUT_EN
      count_q     <= count_d;
`endif
    end
  end

  assign bus.mem_req   = (state_q == ST_REQ);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_rdata = rdata_q;
  assign bus.cpu_err   = (state_q == ST_DONE) && err_q;
  assign bus.cpu_ready = (state_q == ST_DONE) || ((state_q == ST_IDLE) && !req_in);

endmodule

// File: tb/tb_dmem_bridge.sv
// Randomized + directed bench for dmem_bridge against a lane-arithmetic model.
module tb_dmem_bridge;
  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_bad   = 0;
  logic [31:0] exp_rdata = 32'h0;

  dmem_bridge_if bus ();
  dmem_bridge #(.TIMEOUT_CYCLES(16)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int sz(input logic [2:0] t);
    case (t)
      3'd1, 3'd2: return 2;
      3'd3, 3'd4: return 1;
      default:    return 4;
    endcase
  endfunction

  function automatic bit misal(input logic [2:0] t, input logic [31:0] a);
    return (int'(a[1:0]) % sz(t)) != 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] t, input logic [31:0] a);
    int s = sz(t);
    int off = (s == 4) ? 0 : int'(a[1:0]);
    int m = ((1 << s) - 1) << off;
    return m[3:0];
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] t, input logic [31:0] wd);
    int s = sz(t);
    longint low = longint'(wd) & ((longint'(1) << (8 * s)) - 1);
    longint r = 0;
    for (int k = 0; k < 4 / s; k++) r = r | (low << (k * 8 * s));
    return r[31:0];
  endfunction

  function automatic logic [31:0] exp_rd(input logic [2:0] t, input logic [31:0] a,
                                         input logic [31:0] rd);
    int s = sz(t);
    int sh = (s == 4) ? 0 : 8 * int'(a[1:0]);
    longint lim = longint'(1) << (8 * s);
    longint v = (longint'(rd) >> sh) & (lim - 1);
    if ((t == 3'd1 || t == 3'd3) && v >= lim / 2) v = v - lim;
    return v[31:0];
  endfunction

  // Entry/exit: just after a rising edge with the bridge idle.
  task automatic access(input string tag, input bit w, input bit r, input logic [2:0] t,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int lat);
    bit mis = misal(t, a);
    bus.cpu_mem_w = w; bus.cpu_mem_r = r; bus.cpu_dm_type = t;
    bus.cpu_addr = a; bus.cpu_wdata = wd;
    @(negedge clk);
    chk({tag, " ready_req"}, 32'(bus.cpu_ready), 32'd0);
    @(posedge clk); #1;
    bus.cpu_mem_w = 1'b0; bus.cpu_mem_r = 1'b0;
    bus.cpu_addr = $urandom; bus.cpu_wdata = $urandom; bus.cpu_dm_type = 3'($urandom);
    if (!mis) begin
      for (int c = 0; c <= lat; c++) begin
        bus.mem_ack   = (c == lat);
        bus.mem_rdata = (c == lat) ? rd : $urandom;
        @(negedge clk);
        chk({tag, " mem_req"}, 32'(bus.mem_req), 32'd1);
        chk({tag, " ready_stall"}, 32'(bus.cpu_ready), 32'd0);
        if (c == lat) begin
          chk({tag, " mem_addr"}, bus.mem_addr, a & 32'hFFFF_FFFC);
          chk({tag, " mem_be"}, 32'(bus.mem_be), 32'(exp_be(t, a)));
          chk({tag, " mem_we"}, 32'(bus.mem_we), 32'(w));
          if (w) chk({tag, " mem_wdata"}, bus.mem_wdata, exp_wd(t, wd));
        end
        @(posedge clk); #1;
      end
      bus.mem_ack = 1'b0;
      if (!w) exp_rdata = exp_rd(t, a, rd);
    end
    @(negedge clk);
    chk({tag, " done_ready"}, 32'(bus.cpu_ready), 32'd1);
    chk({tag, " done_err"}, 32'(bus.cpu_err), 32'(mis));
    chk({tag, " done_req"}, 32'(bus.mem_req), 32'd0);
    chk({tag, " rdata"}, bus.cpu_rdata, exp_rdata);
    if (!mis) begin
      chk({tag, " hold_addr"}, bus.mem_addr, a & 32'hFFFF_FFFC);
      chk({tag, " hold_be"}, 32'(bus.mem_be), 32'(exp_be(t, a)));
      chk({tag, " hold_we"}, 32'(bus.mem_we), 32'(w));
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, " idle_err"}, 32'(bus.cpu_err), 32'd0);
    chk({tag, " idle_req"}, 32'(bus.mem_req), 32'd0);
    chk({tag, " idle_ready"}, 32'(bus.cpu_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.cpu_mem_w = 1'b0; bus.cpu_mem_r = 1'b0; bus.cpu_dm_type = 3'd0;
    bus.cpu_addr = 32'h0; bus.cpu_wdata = 32'h0; bus.mem_rdata = 32'h0; bus.mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst mem_be", 32'(bus.mem_be), 32'd0);
    chk("rst cpu_err", 32'(bus.cpu_err), 32'd0);
    chk("rst cpu_rdata", bus.cpu_rdata, 32'd0);
    chk("rst mem_addr", bus.mem_addr, 32'd0);
    chk("rst mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst ready", 32'(bus.cpu_ready), 32'd1);
    @(posedge clk); #1;

    access("sw10", 1'b1, 1'b0, 3'd0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    access("lb13", 1'b0, 1'b1, 3'd3, 32'h13, 32'h0, 32'h80FF0011, 1);
    chk("lb13 const", bus.cpu_rdata, 32'hFFFFFF80);
    access("lbu13", 1'b0, 1'b1, 3'd4, 32'h13, 32'h0, 32'h80FF0011, 0);
    chk("lbu13 const", bus.cpu_rdata, 32'h00000080);
    access("sh22", 1'b1, 1'b0, 3'd1, 32'h22, 32'h1234ABCD, 32'h0, 2);
    access("lw06", 1'b0, 1'b1, 3'd0, 32'h06, 32'h0, 32'h0, 0);
    access("lh21", 1'b0, 1'b1, 3'd1, 32'h21, 32'h0, 32'h0, 0);
    access("both", 1'b1, 1'b1, 3'd0, 32'h44, 32'h0BADF00D, 32'h5555AAAA, 1);
    access("lhu", 1'b0, 1'b1, 3'd2, 32'h52, 32'h0, 32'hF00D8001, 0);
`ifndef DMEM_TIMEOUT_EN
    access("longwait", 1'b0, 1'b1, 3'd0, 32'h60, 32'h0, 32'hCAFEF00D, 20);
`endif

    for (int i = 0; i < 60; i++) begin
      logic [2:0] t = 3'($urandom_range(0, 4));
      bit w = bit'($urandom_range(0, 1));
      access("rnd", w, ~w, t, $urandom, $urandom, $urandom, int'($urandom_range(0, 4)));
    end

    // reset while in REQ, then a stale ack
    bus.cpu_mem_r = 1'b1; bus.cpu_dm_type = 3'd0; bus.cpu_addr = 32'h40;
    @(posedge clk); #1;
    bus.cpu_mem_r = 1'b0;
    @(negedge clk);
    chk("rreq mem_req", 32'(bus.mem_req), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h12345678;
    exp_rdata = 32'h0;
    @(negedge clk);
    chk("rreq req_after", 32'(bus.mem_req), 32'd0);
    chk("rreq err_after", 32'(bus.cpu_err), 32'd0);
    chk("rreq rdata", bus.cpu_rdata, 32'd0);
    chk("rreq be", 32'(bus.mem_be), 32'd0);
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("stale req", 32'(bus.mem_req), 32'd0);
    chk("stale err", 32'(bus.cpu_err), 32'd0);
    chk("stale rdata", bus.cpu_rdata, 32'd0);
    @(posedge clk); #1;
    access("post_rst", 1'b0, 1'b1, 3'd0, 32'h48, 32'h0, 32'h89ABCDEF, 0);

`ifdef DMEM_TIMEOUT_EN
    begin
      int cnt = 0;
      logic [31:0] keep = bus.cpu_rdata;
      bus.cpu_mem_r = 1'b1; bus.cpu_dm_type = 3'd0; bus.cpu_addr = 32'h80;
      @(posedge clk); #1;
      bus.cpu_mem_r = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (!bus.mem_req) break;
        cnt++;
        @(posedge clk);
      end
      chk("tmo req_cycles", 32'(cnt), 32'd16);
      chk("tmo err", 32'(bus.cpu_err), 32'd1);
      chk("tmo ready", 32'(bus.cpu_ready), 32'd1);
      chk("tmo rdata", bus.cpu_rdata, keep);
      @(posedge clk); #1;
      @(negedge clk);
      chk("tmo idle_err", 32'(bus.cpu_err), 32'd0);
      chk("tmo idle_req", 32'(bus.mem_req), 32'd0);
      chk("tmo idle_ready", 32'(bus.cpu_ready), 32'd1);
      @(posedge clk); #1;
    end
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
